// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: ALU opcode constants,
// MDU operation and state enums, and the ALUOp-to-MDU decode helper.
package mdu_pkg;

  localparam int DIV_CYCLES = 32;

  localparam logic [4:0] AluOp_Add   = 5'd0;
  localparam logic [4:0] AluOp_Addu  = 5'd1;
  localparam logic [4:0] AluOp_Sub   = 5'd2;
  localparam logic [4:0] AluOp_Subu  = 5'd3;
  localparam logic [4:0] AluOp_And   = 5'd4;
  localparam logic [4:0] AluOp_Or    = 5'd5;
  localparam logic [4:0] AluOp_Xor   = 5'd6;
  localparam logic [4:0] AluOp_Nor   = 5'd7;
  localparam logic [4:0] AluOp_Slt   = 5'd8;
  localparam logic [4:0] AluOp_Sltu  = 5'd9;
  localparam logic [4:0] AluOp_Sll   = 5'd10;
  localparam logic [4:0] AluOp_Srl   = 5'd11;
  localparam logic [4:0] AluOp_Sra   = 5'd12;
  localparam logic [4:0] AluOp_Lui   = 5'd13;
  localparam logic [4:0] AluOp_Mul   = 5'd14;
  localparam logic [4:0] AluOp_Mult  = 5'd15;
  localparam logic [4:0] AluOp_Multu = 5'd16;
  localparam logic [4:0] AluOp_Madd  = 5'd17;
  localparam logic [4:0] AluOp_Maddu = 5'd18;
  localparam logic [4:0] AluOp_Msub  = 5'd19;
  localparam logic [4:0] AluOp_Msubu = 5'd20;
  localparam logic [4:0] AluOp_Div   = 5'd21;
  localparam logic [4:0] AluOp_Divu  = 5'd22;
  localparam logic [4:0] AluOp_Mthi  = 5'd23;
  localparam logic [4:0] AluOp_Mtlo  = 5'd24;
  localparam logic [4:0] AluOp_Mfhi  = 5'd25;
  localparam logic [4:0] AluOp_Mflo  = 5'd26;

  typedef enum logic [3:0] {
    MUL_S, MUL_U, MADD_S, MADD_U, MSUB_S, MSUB_U, DIV_S, DIV_U,
    MTHI, MTLO, MFHI, MFLO, NONE
  } mdu_op_e;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_e;

  // Mul writes a GPR through the main ALU path, so it is deliberately not an MDU op.
  function automatic mdu_op_e mdu_decode(input logic [4:0] alu_op);
    mdu_op_e op;
    op = NONE;
    case (alu_op)
      AluOp_Mult:  op = MUL_S;
      AluOp_Multu: op = MUL_U;
      AluOp_Madd:  op = MADD_S;
      AluOp_Maddu: op = MADD_U;
      AluOp_Msub:  op = MSUB_S;
      AluOp_Msubu: op = MSUB_U;
      AluOp_Div:   op = DIV_S;
      AluOp_Divu:  op = DIV_U;
      AluOp_Mthi:  op = MTHI;
      AluOp_Mtlo:  op = MTLO;
      AluOp_Mfhi:  op = MFHI;
      AluOp_Mflo:  op = MFLO;
      default:     op = NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring 32-bit unsigned divider: loads on start, one quotient bit
// per cycle, q/r hold the result once the final iteration has retired.
module mdu_divider
  import mdu_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_CYCLES - 1);

  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [32:0] trial;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    // A zero divisor never borrows, leaving q all ones and r equal to the dividend.
    trial  = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (!trial[32]) begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = {rem_q[30:0], quo_q[31]};
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == LAST_ITER) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done = busy_q && (cnt_q == LAST_ITER) && !abort;
  assign q    = quo_q;
  assign r    = rem_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO: runs multi-cycle mult/div ops,
// raises Stall on HI/LO hazards and exposes HI/LO to the EX result mux.
module hilo_muldiv_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DATA_W      = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              Valid,
  input  logic [4:0]        ALUOp,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              Flush,
  output logic              Stall,
  output logic              Busy,
  output logic [DATA_W-1:0] HiOut,
  output logic [DATA_W-1:0] LoOut
);

  localparam int CNT_W = (MULT_CYCLES > 2) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MULT_CYCLES > 1) ? MULT_CYCLES - 2 : 0);

  mdu_state_e       state_q, state_d;
  mdu_op_e          op_q, op_d, dec_op;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [63:0]      prod_q, prod_d, acc;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             md_op, sgn, div_start, div_abort, div_done;
  logic signed [63:0] op_a, op_b;
  logic [31:0]      a_abs, b_abs, div_q, div_r;

  always_comb begin
    dec_op = mdu_decode(ALUOp);
    md_op  = Valid && (dec_op != NONE) && !Flush;
    Busy   = (state_q == MUL) || (state_q == DIV);
    Stall  = md_op && (Busy || (state_q == DONE));
    sgn    = (dec_op == MUL_S) || (dec_op == MADD_S) || (dec_op == MSUB_S) || (dec_op == DIV_S);
    // 33-bit extension lets one signed multiplier serve both signednesses.
    op_a   = 64'($signed({sgn & A[31], A}));
    op_b   = 64'($signed({sgn & B[31], B}));
    a_abs  = (sgn && A[31]) ? -A : A;
    b_abs  = (sgn && B[31]) ? -B : B;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prod_d    = prod_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    div_start = 1'b0;
    div_abort = 1'b0;
    acc       = {hi_q, lo_q};
    case (state_q)
      IDLE: begin
        if (md_op) begin
          case (dec_op)
            MTHI: hi_d = A;
            MTLO: lo_d = A;
            MUL_S, MUL_U, MADD_S, MADD_U, MSUB_S, MSUB_U: begin
              op_d   = dec_op;
              prod_d = op_a * op_b;
              cnt_d  = '0;
              if (MULT_CYCLES > 1) state_d = MUL;
              else                 state_d = DONE;
            end
            DIV_S, DIV_U: begin
              op_d      = dec_op;
              div_start = 1'b1;
              // Quotient sign is left positive on divide-by-zero so LO reads all ones.
              qneg_d    = sgn && (A[31] ^ B[31]) && (B != '0);
              rneg_d    = sgn && A[31];
              state_d   = DIV;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        if (Flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == MUL_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DIV: begin
        if (Flush) begin
          state_d   = IDLE;
          div_abort = 1'b1;
        end else if (div_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        // The accumulator is read here, so Mthi/Mtlo issued before the op still count.
        if (!Flush) begin
          case (op_q)
            MUL_S, MUL_U:   {hi_d, lo_d} = prod_q;
            MADD_S, MADD_U: {hi_d, lo_d} = acc + prod_q;
            MSUB_S, MSUB_U: {hi_d, lo_d} = acc - prod_q;
            DIV_S, DIV_U: begin
              lo_d = qneg_q ? -div_q : div_q;
              hi_d = rneg_q ? -div_r : div_r;
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= NONE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  mdu_divider u_divider (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (a_abs),
    .divisor  (b_abs),
    .done     (div_done),
    .q        (div_q),
    .r        (div_r)
  );

  assign HiOut = hi_q;
  assign LoOut = lo_q;

endmodule
